// File: rtl/rv64g_pkg.sv
// rv64g_pkg: shared sizing constants for the rv64g register lock manager
//   NUM_REGS        - architectural registers tracked (x0..x31, f0..f31)
//   NUM_OUTSTANDING - maximum simultaneously locked destinations
//   locks_t         - one bit per tracked register
package rv64g_pkg;
   localparam int NUM_REGS        = 64;
   localparam int NUM_OUTSTANDING = 8;
   typedef logic [NUM_REGS-1:0] locks_t;
endpackage

// File: rtl/rv64g_lock_manager_if.sv
// rv64g_lock_manager_if: launch/writeback/lock bundle between launcher and lock manager
//   master: drives clear_i, launch_valid_i, launch_rd_i, launch_we_i, wb_valid_i, wb_rd_i
//           and observes launch_ready_o, locks_o, outstanding_o, err_o
//   slave:  the lock manager side, directions mirrored
interface rv64g_lock_manager_if
   import rv64g_pkg::*;
#(
   parameter int NR      = NUM_REGS,
   parameter int MAX_OUT = NUM_OUTSTANDING,
   parameter int NUM_WB  = 2
) ();
   logic                                clear_i;
   logic                                launch_valid_i;
   logic                                launch_ready_o;
   logic [$clog2(NR)-1:0]               launch_rd_i;
   logic                                launch_we_i;
   logic [NUM_WB-1:0]                   wb_valid_i;
   logic [NUM_WB-1:0][$clog2(NR)-1:0]   wb_rd_i;
   logic [NR-1:0]                       locks_o;
   logic [$clog2(MAX_OUT+1)-1:0]        outstanding_o;
   logic                                err_o;
   modport master (
      output clear_i, launch_valid_i, launch_rd_i, launch_we_i, wb_valid_i, wb_rd_i,
      input  launch_ready_o, locks_o, outstanding_o, err_o
   );
   modport slave (
      input  clear_i, launch_valid_i, launch_rd_i, launch_we_i, wb_valid_i, wb_rd_i,
      output launch_ready_o, locks_o, outstanding_o, err_o
   );
endinterface

// File: rtl/rv64g_wb_decoder.sv
// rv64g_wb_decoder: OR of one-hot decodes of NUM_WB (valid, rd) writeback pairs
//   valid - per-port writeback strobe
//   rd    - per-port writeback register index
//   mask  - NR-bit clear mask; duplicate registers collapse to one bit
module rv64g_wb_decoder #(
   parameter int NR     = 64,
   parameter int NUM_WB = 2
) (
   input  logic [NUM_WB-1:0]                 valid,
   input  logic [NUM_WB-1:0][$clog2(NR)-1:0] rd,
   output logic [NR-1:0]                     mask
);
   always_comb begin
      mask = '0;
      for (int p = 0; p < NUM_WB; p++)
         mask = mask | (valid[p] ? (NR'(1) << rd[p]) : '0);
   end
endmodule

// File: rtl/rv64g_lock_manager.sv
// rv64g_lock_manager: per-register write-pending scoreboard for the rv64g launcher
//   clk_i - clock, rst_i - synchronous active-high reset
//   bus   - rv64g_lock_manager_if.slave: launch handshake, writeback ports, clear_i flush,
//           locks_o / outstanding_o / sticky err_o
//   Macro RV64G_LOCK_WB_BYPASS_EN: locks_o drops current-cycle writebacks combinationally.
module rv64g_lock_manager
   import rv64g_pkg::*;
#(
   parameter int NR      = NUM_REGS,
   parameter int MAX_OUT = NUM_OUTSTANDING,
   parameter int NUM_WB  = 2
) (
   input logic                 clk_i,
   input logic                 rst_i,
   rv64g_lock_manager_if.slave bus
);
   localparam int CW = $clog2(MAX_OUT+1);
   logic [NR-1:0] locks_q, clr, set, nxt;
   logic [CW-1:0] out_q;
   logic          err_q, acc, lwr, wb_err, ln_err;
   int            cnt;

   rv64g_wb_decoder #(.NR(NR), .NUM_WB(NUM_WB)) u_dec (
      .valid (bus.wb_valid_i),
      .rd    (bus.wb_rd_i),
      .mask  (clr)
   );

   assign bus.launch_ready_o = (out_q < CW'(MAX_OUT)) | ~bus.launch_we_i | ~|bus.launch_rd_i;
   assign acc = bus.launch_valid_i & bus.launch_ready_o;
   assign lwr = acc & bus.launch_we_i & |bus.launch_rd_i;
   assign set = lwr ? (NR'(1) << bus.launch_rd_i) : '0;
   // clear first, then set, so a same-cycle writeback and relaunch leaves the lock held
   assign nxt = ((locks_q & ~clr) | set) & ~NR'(1);
   assign wb_err = |(clr & ~locks_q & ~NR'(1));
   assign ln_err = lwr & locks_q[bus.launch_rd_i] & ~clr[bus.launch_rd_i];

   always_comb begin
      cnt = 0;
      for (int i = 0; i < NR; i++)
         cnt += int'(nxt[i]);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         locks_q <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else if (bus.clear_i) begin
         locks_q <= '0;
         out_q   <= '0;
      end else begin
         locks_q <= nxt;
         out_q   <= CW'(cnt > MAX_OUT ? MAX_OUT : cnt);
         err_q   <= err_q | wb_err | ln_err;
      end
   end

`ifdef RV64G_LOCK_WB_BYPASS_EN
   assign bus.locks_o = locks_q & ~clr;
`else
   assign bus.locks_o = locks_q;
`endif
   assign bus.outstanding_o = out_q;
   assign bus.err_o         = err_q;
endmodule

// File: tb/tb_rv64g_lock_manager.sv
// tb_rv64g_lock_manager: directed self-checking bench for rv64g_lock_manager
module tb_rv64g_lock_manager;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   rv64g_lock_manager_if bus ();

   rv64g_lock_manager dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.clear_i        = 1'b0;
      bus.launch_valid_i = 1'b0;
      bus.launch_we_i    = 1'b0;
      bus.launch_rd_i    = '0;
      bus.wb_valid_i     = '0;
      bus.wb_rd_i        = '0;
   endtask

   task automatic launch(input int rd);
      bus.launch_valid_i = 1'b1;
      bus.launch_we_i    = 1'b1;
      bus.launch_rd_i    = 6'(rd);
      step();
      idle();
   endtask

   task automatic do_clear();
      bus.clear_i = 1'b1;
      step();
      idle();
   endtask

   initial begin
      idle();
      step();
      check("rst_locks", bus.locks_o, 64'h0);
      check("rst_out", 64'(bus.outstanding_o), 64'd0);
      check("rst_err", 64'(bus.err_o), 64'd0);
      check("rst_ready", 64'(bus.launch_ready_o), 64'd1);
      rst = 1'b0;

      launch(5);
      check("l5_locks", bus.locks_o, 64'h20);
      check("l5_out", 64'(bus.outstanding_o), 64'd1);

      bus.wb_valid_i = 2'b01;
      bus.wb_rd_i[0] = 6'd5;
      #1;
`ifdef RV64G_LOCK_WB_BYPASS_EN
      check("wb5_bypass", bus.locks_o, 64'h0);
`else
      check("wb5_held", bus.locks_o, 64'h20);
`endif
      step();
      idle();
      check("wb5_locks", bus.locks_o, 64'h0);
      check("wb5_out", 64'(bus.outstanding_o), 64'd0);
      check("wb5_err", 64'(bus.err_o), 64'd0);

      for (int r = 1; r <= 8; r++) launch(r);
      check("full_locks", bus.locks_o, 64'h1FE);
      check("full_out", 64'(bus.outstanding_o), 64'd8);
      bus.launch_valid_i = 1'b1;
      bus.launch_we_i    = 1'b1;
      bus.launch_rd_i    = 6'd40;
      #1;
      check("full_ready_we1", 64'(bus.launch_ready_o), 64'd0);
      step();
      check("full_blocked", bus.locks_o, 64'h1FE);
      check("full_out_hold", 64'(bus.outstanding_o), 64'd8);
      bus.launch_we_i = 1'b0;
      #1;
      check("full_ready_we0", 64'(bus.launch_ready_o), 64'd1);
      bus.launch_we_i = 1'b1;
      bus.launch_rd_i = 6'd0;
      #1;
      check("full_ready_rd0", 64'(bus.launch_ready_o), 64'd1);
      idle();
      check("full_err", 64'(bus.err_o), 64'd0);
      do_clear();

      launch(3);
      launch(7);
      check("l37_out", 64'(bus.outstanding_o), 64'd2);
      bus.wb_valid_i     = 2'b11;
      bus.wb_rd_i[0]     = 6'd3;
      bus.wb_rd_i[1]     = 6'd3;
      bus.launch_valid_i = 1'b1;
      bus.launch_we_i    = 1'b1;
      bus.launch_rd_i    = 6'd3;
      step();
      idle();
      check("relock_locks", bus.locks_o, 64'h88);
      check("relock_out", 64'(bus.outstanding_o), 64'd2);
      check("relock_err", 64'(bus.err_o), 64'd0);

      bus.wb_valid_i = 2'b10;
      bus.wb_rd_i[1] = 6'd7;
      step();
      idle();
      check("wb7_locks", bus.locks_o, 64'h08);
      check("wb7_out", 64'(bus.outstanding_o), 64'd1);
      do_clear();

      launch(0);
      check("rd0_locks", bus.locks_o, 64'h0);
      check("rd0_out", 64'(bus.outstanding_o), 64'd0);

      launch(2);
      launch(4);
      launch(6);
      launch(8);
      check("l4_out", 64'(bus.outstanding_o), 64'd4);
      bus.clear_i        = 1'b1;
      bus.launch_valid_i = 1'b1;
      bus.launch_we_i    = 1'b1;
      bus.launch_rd_i    = 6'd2;
      step();
      idle();
      check("flush_locks", bus.locks_o, 64'h0);
      check("flush_out", 64'(bus.outstanding_o), 64'd0);
      check("flush_err", 64'(bus.err_o), 64'd0);

      bus.wb_valid_i = 2'b01;
      bus.wb_rd_i[0] = 6'd9;
      step();
      idle();
      check("wb9_err", 64'(bus.err_o), 64'd1);
      check("wb9_locks", bus.locks_o, 64'h0);
      do_clear();
      check("err_after_clear", 64'(bus.err_o), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("err_after_rst", 64'(bus.err_o), 64'd0);

      launch(12);
      launch(12);
      check("dup_err", 64'(bus.err_o), 64'd1);
      check("dup_out", 64'(bus.outstanding_o), 64'd1);
      rst = 1'b1;
      bus.launch_valid_i = 1'b1;
      bus.launch_we_i    = 1'b1;
      bus.launch_rd_i    = 6'd20;
      step();
      idle();
      rst = 1'b0;
      check("rst_over_locks", bus.locks_o, 64'h0);
      check("rst_over_err", 64'(bus.err_o), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/rv64g_lock_manager.md
RV64G_LOCK_MANAGER -- requirements
Module: rv64g_lock_manager

Interface
REQ-001 SHALL have parameter NR, default rv64g_pkg::NUM_REGS, number of architectural registers tracked (x0..x31, f0..f31).
REQ-002 SHALL have parameter MAX_OUT, default rv64g_pkg::NUM_OUTSTANDING, maximum simultaneously locked destinations.
REQ-003 SHALL have parameter NUM_WB, default 2, number of independent writeback ports.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clear_i, input, 1, synchronous pipeline flush.
REQ-007 SHALL have port launch_valid_i, input, 1, launcher presents an instruction.
REQ-008 SHALL have port launch_ready_o, output, 1, lock manager accepts the launch.
REQ-009 SHALL have port launch_rd_i, input, $clog2(NR), destination register of the launched instruction.
REQ-010 SHALL have port launch_we_i, input, 1, launched instruction writes rd.
REQ-011 SHALL have port wb_valid_i, input, NUM_WB, per-port writeback strobe.
REQ-012 SHALL have port wb_rd_i, input, NUM_WB x $clog2(NR), per-port writeback register.
REQ-013 SHALL have port locks_o, output, NR, one bit per register, 1 = write pending; drives launcher locks_i.
REQ-014 SHALL have port outstanding_o, output, $clog2(MAX_OUT+1), count of set lock bits.
REQ-015 SHALL have port err_o, output, 1, sticky protocol-violation flag.

Function
REQ-016 SHALL accept a launch on the rising edge where launch_valid_i and launch_ready_o are both 1.
REQ-017 SHALL drive launch_ready_o = 1 iff outstanding_o < MAX_OUT, or launch_we_i = 0, or launch_rd_i = 0.
REQ-018 SHALL set locks_o[launch_rd_i] on the edge after an accepted launch with launch_we_i = 1 and launch_rd_i != 0.
REQ-019 SHALL clear locks_o[wb_rd_i[p]] on the edge after wb_valid_i[p] = 1, for every port p.
REQ-020 SHALL hold locks_o[0] at 0 permanently; launches and writebacks to register 0 are no-ops.
REQ-021 SHALL, on same-cycle clear and set of one register, leave it set (clear applied first, then set).
REQ-022 SHALL treat multiple ports writing back the same register in one cycle as one clear.
REQ-023 SHALL set err_o on a writeback to an unlocked nonzero register, or a launch to an already-locked register that is not being cleared that cycle; err_o clears only on rst_i.
REQ-024 SHALL update outstanding_o each edge as previous + sets - effective clears, never wrapping below 0 or above MAX_OUT.
REQ-025 SHALL, when clear_i = 1, zero locks_o and outstanding_o on the next edge, ignoring same-cycle launch and writeback; err_o unaffected.
REQ-026 SHALL have 1-cycle launch-to-lock latency and 1-cycle writeback-to-unlock latency, unless REQ-030 applies.

Reset
REQ-027 SHALL, on an edge with rst_i = 1, set locks_o = 0, outstanding_o = 0 and err_o = 0; rst_i overrides clear_i, launch and writeback.
REQ-028 SHALL drive launch_ready_o = 1 during and after reset, since outstanding_o = 0.

Configuration
REQ-029 SHALL recognise macro RV64G_LOCK_WB_BYPASS_EN.
REQ-030 SHALL, when RV64G_LOCK_WB_BYPASS_EN is defined, drive locks_o combinationally as the registered locks with the current-cycle wb_valid_i clears removed, giving 0-cycle writeback-to-unlock.
REQ-031 SHALL, when the macro is undefined, drive locks_o directly from the lock register; all other behaviour is identical.

Structure
REQ-032 SHALL take NUM_REGS and NUM_OUTSTANDING from rv64g_pkg; no new package typedefs except locks_t if not already present.
REQ-033 SHALL use one sub-module, rv64g_wb_decoder, converting NUM_WB (valid, rd) pairs into an NR-bit one-hot-OR clear mask.

Verification
REQ-034 SHALL cover: reset, then launch rd=5 we=1 -> locks_o[5]=1 next cycle, outstanding_o=1.
REQ-035 SHALL cover: locks_o[5]=1, wb_valid_i=01 wb_rd=5 -> locks_o[5]=0 next cycle (same cycle with the bypass macro), outstanding_o=0.
REQ-036 SHALL cover: MAX_OUT launches to rd=1..MAX_OUT -> launch_ready_o=0 for rd=40 we=1, but 1 for we=0.
REQ-037 SHALL cover: locks {3,7} set, wb ports 0 and 1 both rd=3 while launching rd=3 -> locks_o[3]=1, outstanding_o=2, err_o=0.
REQ-038 SHALL cover: wb rd=9 while unlocked -> err_o=1 and stays 1 through clear_i, 0 after rst_i.
REQ-039 SHALL cover: 4 locks set, clear_i=1 with a simultaneous launch rd=2 -> locks_o=0, outstanding_o=0.
